// File: rtl/motion_update_broadcaster.sv
// rtl/motion_update_broadcaster.sv - walks every cell, reads positions and displacements, broadcasts wrapped updated positions
module motion_update_broadcaster #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 8,
  parameter int CELL_ID_WIDTH = 4,
  parameter int PARTICLE_NUM  = 220,
  parameter int NUM_CELL_X    = 3,
  parameter int NUM_CELL_Y    = 3,
  parameter int NUM_CELL_Z    = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  output logic [3*CELL_ID_WIDTH-1:0] out_read_cell,
  output logic [ADDR_WIDTH-1:0]      out_read_address,
  output logic                       out_rden,
  input  logic [3*DATA_WIDTH-1:0]    in_pos,
  input  logic [3*DATA_WIDTH-1:0]    in_disp,
  output logic                       out_motion_update_enable,
  output logic [3*DATA_WIDTH-1:0]    out_data,
  output logic [3*CELL_ID_WIDTH-1:0] out_data_dst_cell,
  output logic                       out_data_valid,
  output logic                       busy,
  output logic                       done
);

  localparam logic [ADDR_WIDTH-1:0]    MAX_COUNT = ADDR_WIDTH'(PARTICLE_NUM - 1);
  localparam logic [CELL_ID_WIDTH-1:0] ONE_CELL  = CELL_ID_WIDTH'(1);
  localparam logic [CELL_ID_WIDTH-1:0] NX        = CELL_ID_WIDTH'(NUM_CELL_X);
  localparam logic [CELL_ID_WIDTH-1:0] NY        = CELL_ID_WIDTH'(NUM_CELL_Y);
  localparam logic [CELL_ID_WIDTH-1:0] NZ        = CELL_ID_WIDTH'(NUM_CELL_Z);
  localparam logic [CELL_ID_WIDTH-1:0] NX_P1     = CELL_ID_WIDTH'(NUM_CELL_X + 1);
  localparam logic [CELL_ID_WIDTH-1:0] NY_P1     = CELL_ID_WIDTH'(NUM_CELL_Y + 1);
  localparam logic [CELL_ID_WIDTH-1:0] NZ_P1     = CELL_ID_WIDTH'(NUM_CELL_Z + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_READ_COUNT, S_WAIT_COUNT, S_STREAM, S_DRAIN, S_RELEASE, S_DONE
  } state_t;

  state_t                    r_state;
  logic [CELL_ID_WIDTH-1:0]  r_cell_x, r_cell_y, r_cell_z;
  logic [ADDR_WIDTH-1:0]     r_read_address;
  logic [ADDR_WIDTH-1:0]     r_count;
  logic                      r_rden;
  logic                      r_phase;
  logic                      r_pend;
  logic                      r_enable;
  logic                      r_valid;
  logic [3*DATA_WIDTH-1:0]   r_data;
  logic [3*CELL_ID_WIDTH-1:0] r_dst;
  logic                      r_busy;
  logic                      r_done;

  logic [ADDR_WIDTH-1:0]     w_count_clamped;
  logic                      w_last_cell;
  logic                      w_cell_end;
  logic [CELL_ID_WIDTH-1:0]  w_next_x, w_next_y, w_next_z;
  logic [DATA_WIDTH-1:0]     w_new_x, w_new_y, w_new_z;

  // Add displacement, then fold a one-cell overshoot of the top field back into the periodic box
  function automatic logic [DATA_WIDTH-1:0] wrap_axis(
    input logic [DATA_WIDTH-1:0]    pos,
    input logic [DATA_WIDTH-1:0]    disp,
    input logic [CELL_ID_WIDTH-1:0] n_cell,
    input logic [CELL_ID_WIDTH-1:0] n_cell_p1
  );
    logic [DATA_WIDTH-1:0]    sum;
    logic [CELL_ID_WIDTH-1:0] field;
    sum   = pos + disp;
    field = sum[DATA_WIDTH-1 -: CELL_ID_WIDTH];
    if (field == '0)
      field = n_cell;
    else if (field == n_cell_p1)
      field = ONE_CELL;
    sum[DATA_WIDTH-1 -: CELL_ID_WIDTH] = field;
    return sum;
  endfunction

  assign w_new_x = wrap_axis(in_pos[DATA_WIDTH-1:0], in_disp[DATA_WIDTH-1:0], NX, NX_P1);
  assign w_new_y = wrap_axis(in_pos[2*DATA_WIDTH-1:DATA_WIDTH], in_disp[2*DATA_WIDTH-1:DATA_WIDTH], NY, NY_P1);
  assign w_new_z = wrap_axis(in_pos[3*DATA_WIDTH-1:2*DATA_WIDTH], in_disp[3*DATA_WIDTH-1:2*DATA_WIDTH], NZ, NZ_P1);

  assign w_count_clamped = (in_pos[ADDR_WIDTH-1:0] > MAX_COUNT) ? MAX_COUNT : in_pos[ADDR_WIDTH-1:0];
  assign w_last_cell     = (r_cell_x == NX) && (r_cell_y == NY) && (r_cell_z == NZ);
  assign w_cell_end      = ((r_state == S_WAIT_COUNT) && (w_count_clamped == '0)) ||
                           ((r_state == S_STREAM) && (r_read_address == r_count));

  // Next cell in scan order: z fastest, then y, then x
  always_comb begin
    w_next_x = r_cell_x;
    w_next_y = r_cell_y;
    w_next_z = r_cell_z + ONE_CELL;
    if (r_cell_z == NZ) begin
      w_next_z = ONE_CELL;
      w_next_y = r_cell_y + ONE_CELL;
      if (r_cell_y == NY) begin
        w_next_y = ONE_CELL;
        w_next_x = r_cell_x + ONE_CELL;
      end
    end
  end

  // Pass sequencer plus the two-stage read-to-output pipeline
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_cell_x       <= '0;
      r_cell_y       <= '0;
      r_cell_z       <= '0;
      r_read_address <= '0;
      r_count        <= '0;
      r_rden         <= 1'b0;
      r_phase        <= 1'b0;
      r_pend         <= 1'b0;
      r_enable       <= 1'b0;
      r_valid        <= 1'b0;
      r_data         <= '0;
      r_dst          <= '0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      // A particle address issued last cycle has its readout on the inputs now
      r_pend  <= r_rden && (r_read_address != '0);
      r_valid <= r_pend;
      r_data  <= r_pend ? {w_new_z, w_new_y, w_new_x} : '0;
      r_dst   <= r_pend ? {w_new_x[DATA_WIDTH-1 -: CELL_ID_WIDTH],
                           w_new_y[DATA_WIDTH-1 -: CELL_ID_WIDTH],
                           w_new_z[DATA_WIDTH-1 -: CELL_ID_WIDTH]} : '0;

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state        <= S_READ_COUNT;
            r_cell_x       <= ONE_CELL;
            r_cell_y       <= ONE_CELL;
            r_cell_z       <= ONE_CELL;
            r_busy         <= 1'b1;
            r_enable       <= 1'b1;
            r_rden         <= 1'b1;
            r_read_address <= '0;
          end
        end
        S_READ_COUNT: begin
          r_rden  <= 1'b0;
          r_state <= S_WAIT_COUNT;
        end
        S_WAIT_COUNT, S_STREAM: begin
          if (r_state == S_WAIT_COUNT)
            r_count <= w_count_clamped;
          if (w_cell_end) begin
            r_read_address <= '0;
            if (w_last_cell) begin
              r_state <= S_DRAIN;
              r_rden  <= 1'b0;
              r_phase <= 1'b0;
            end else begin
              r_state  <= S_READ_COUNT;
              r_rden   <= 1'b1;
              r_cell_x <= w_next_x;
              r_cell_y <= w_next_y;
              r_cell_z <= w_next_z;
            end
          end else if (r_state == S_WAIT_COUNT) begin
            r_state        <= S_STREAM;
            r_rden         <= 1'b1;
            r_read_address <= ADDR_WIDTH'(1);
          end else begin
            r_read_address <= r_read_address + ADDR_WIDTH'(1);
          end
        end
        S_DRAIN: begin
          r_phase <= ~r_phase;
          if (r_phase) begin
            r_state  <= S_RELEASE;
            r_enable <= 1'b0;
          end
        end
        S_RELEASE: begin
          r_phase <= ~r_phase;
          if (r_phase) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end
        end
        S_DONE: begin
          r_state  <= S_IDLE;
          r_cell_x <= '0;
          r_cell_y <= '0;
          r_cell_z <= '0;
          r_count  <= '0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign out_read_cell            = {r_cell_x, r_cell_y, r_cell_z};
  assign out_read_address         = r_read_address;
  assign out_rden                 = r_rden;
  assign out_motion_update_enable = r_enable;
  assign out_data                 = r_data;
  assign out_data_dst_cell        = r_dst;
  assign out_data_valid           = r_valid;
  assign busy                     = r_busy;
  assign done                     = r_done;

endmodule

// File: tb/tb_motion_update_broadcaster.sv
// tb/tb_motion_update_broadcaster.sv - randomized self-checking bench against a cell-scan reference model
module tb_motion_update_broadcaster;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [11:0]  out_read_cell;
  logic [7:0]   out_read_address;
  logic         out_rden;
  logic [95:0]  in_pos;
  logic [95:0]  in_disp;
  logic         out_motion_update_enable;
  logic [95:0]  out_data;
  logic [11:0]  out_data_dst_cell;
  logic         out_data_valid;
  logic         busy;
  logic         done;

  int errors = 0;
  int checks = 0;

  logic [95:0]  pos_mem  [27][220];
  logic [95:0]  disp_mem [27][220];
  logic [19:0]  exp_rd[$];
  logic [107:0] exp_out[$];
  int           addr_t[$];
  logic [107:0] cap_out[$];

  motion_update_broadcaster dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .start                    (start),
    .out_read_cell            (out_read_cell),
    .out_read_address         (out_read_address),
    .out_rden                 (out_rden),
    .in_pos                   (in_pos),
    .in_disp                  (in_disp),
    .out_motion_update_enable (out_motion_update_enable),
    .out_data                 (out_data),
    .out_data_dst_cell        (out_data_dst_cell),
    .out_data_valid           (out_data_valid),
    .busy                     (busy),
    .done                     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int cell_idx(input logic [11:0] c);
    int x, y, z;
    x = int'(c[11:8]);
    y = int'(c[7:4]);
    z = int'(c[3:0]);
    if (x < 1 || x > 3 || y < 1 || y > 3 || z < 1 || z > 3) return 0;
    return (x - 1) * 9 + (y - 1) * 3 + (z - 1);
  endfunction

  // Cell caches: one-cycle read latency, junk on the bus when not reading
  always @(posedge clk) begin : mem_model
    int c;
    if (out_rden) begin
      c = cell_idx(out_read_cell);
      in_pos  <= pos_mem[c][out_read_address];
      in_disp <= disp_mem[c][out_read_address];
    end else begin
      in_pos  <= {$urandom(), $urandom(), $urandom()};
      in_disp <= {$urandom(), $urandom(), $urandom()};
    end
  end

  function automatic logic [31:0] rand_pos();
    logic [31:0] r;
    logic [3:0]  f;
    r = $urandom();
    f = 4'($urandom_range(1, 3));
    r[31:28] = f;
    return r;
  endfunction

  function automatic logic [31:0] rand_disp();
    logic [31:0] m;
    m = $urandom() & 32'h0FFF_FFFF;
    return ($urandom_range(0, 1) == 1) ? -m : m;
  endfunction

  // Reference: periodic box of 3 cells per axis, each cell 2^28 wide
  function automatic logic [31:0] model_axis(input logic [31:0] p, input logic [31:0] d);
    longint s, rest;
    longint f;
    s    = (longint'(p) + longint'(d)) % 64'h1_0000_0000;
    f    = s / 64'h1000_0000;
    rest = s % 64'h1000_0000;
    if (f == 0) f = 3;
    else if (f == 4) f = 1;
    return 32'(f * 64'h1000_0000 + rest);
  endfunction

  task automatic set_cell(input int c, input int cnt_word);
    logic [95:0] w;
    int n;
    w = {$urandom(), $urandom(), $urandom()};
    w[7:0] = 8'(cnt_word);
    pos_mem[c][0] = w;
    n = (cnt_word > 219) ? 219 : cnt_word;
    for (int i = 1; i <= n; i++) begin
      pos_mem[c][i]  = {rand_pos(), rand_pos(), rand_pos()};
      disp_mem[c][i] = {rand_disp(), rand_disp(), rand_disp()};
    end
  endtask

  task automatic clear_cells();
    for (int c = 0; c < 27; c++) set_cell(c, 0);
  endtask

  task automatic run_pass();
    int e_len, k, c, n;
    logic [31:0] px, py, pz, dx, dy, dz, nx, ny, nz;
    exp_rd.delete();
    exp_out.delete();
    addr_t.delete();
    cap_out.delete();
    e_len = 2;
    for (int x = 1; x <= 3; x++)
      for (int y = 1; y <= 3; y++)
        for (int z = 1; z <= 3; z++) begin
          c = (x - 1) * 9 + (y - 1) * 3 + (z - 1);
          n = int'(pos_mem[c][0][7:0]);
          if (n > 219) n = 219;
          e_len += 2 + n;
          exp_rd.push_back({4'(x), 4'(y), 4'(z), 8'd0});
          for (int i = 1; i <= n; i++) begin
            exp_rd.push_back({4'(x), 4'(y), 4'(z), 8'(i)});
            {pz, py, px} = pos_mem[c][i];
            {dz, dy, dx} = disp_mem[c][i];
            nx = model_axis(px, dx);
            ny = model_axis(py, dy);
            nz = model_axis(pz, dz);
            exp_out.push_back({nx[31:28], ny[31:28], nz[31:28], nz, ny, nx});
          end
        end
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (k = 1; k <= e_len + 4; k++) begin
      if (out_rden) begin
        if (exp_rd.size() == 0) chk("rd_extra", 1, 0);
        else chk("rd_addr", {out_read_cell, out_read_address}, exp_rd.pop_front());
        if (out_read_address != 0) addr_t.push_back(k);
      end
      if (out_data_valid) begin
        cap_out.push_back({out_data_dst_cell, out_data});
        if (exp_out.size() == 0) chk("out_extra", 1, 0);
        else chk("out_data", {out_data_dst_cell, out_data}, exp_out.pop_front());
        if (addr_t.size() == 0) chk("lat_noaddr", 1, 0);
        else chk("latency", k, addr_t.pop_front() + 2);
      end
      chk("invariant", {out_data_valid & ~out_motion_update_enable,
                        ~out_data_valid & ((out_data != 0) | (out_data_dst_cell != 0)),
                        ~out_rden & (out_read_address != 0)}, 0);
      chk("enable", out_motion_update_enable, k <= e_len);
      chk("busy", busy, k <= e_len + 2);
      chk("done", done, k == e_len + 3);
      // a start while busy must be ignored
      start = (k == 3);
      @(negedge clk);
    end
    start = 1'b0;
    chk("rd_left", exp_rd.size(), 0);
    chk("out_left", exp_out.size(), 0);
  endtask

  task automatic check_all_zero(input string tag);
    chk(tag, {out_read_cell, out_read_address, out_rden, out_motion_update_enable,
              out_data, out_data_dst_cell, out_data_valid, busy, done}, 0);
  endtask

  initial begin
    logic [95:0] w;
    int hit;
    rst_n = 1'b0;
    start = 1'b0;
    in_pos = '0;
    in_disp = '0;
    for (int c = 0; c < 27; c++)
      for (int i = 0; i < 220; i++) begin
        pos_mem[c][i]  = '0;
        disp_mem[c][i] = '0;
      end
    #1;
    check_all_zero("reset_outputs");
    repeat (3) @(negedge clk);
    check_all_zero("reset_held");
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("idle_after_reset");

    // all cells empty
    clear_cells();
    run_pass();

    // two particles moving inside cell (1,1,1)
    clear_cells();
    set_cell(0, 2);
    for (int i = 1; i <= 2; i++) begin
      w = pos_mem[0][i];  w[31:0] = 32'h1800_0000; pos_mem[0][i]  = w;
      w = disp_mem[0][i]; w[31:0] = 32'h0100_0000; disp_mem[0][i] = w;
    end
    run_pass();
    chk("n_out_b", cap_out.size(), 2);
    if (cap_out.size() == 2) begin
      w = cap_out[0][95:0];
      chk("x_inside", w[31:0], 32'h1900_0000);
      chk("dst_x_inside", cap_out[0][107:104], 4'd1);
    end

    // wrap up and wrap down across the box edge
    clear_cells();
    set_cell(13, 2);
    w = pos_mem[13][1];  w[31:0] = 32'h3000_0000; pos_mem[13][1]  = w;
    w = disp_mem[13][1]; w[31:0] = 32'h1000_0000; disp_mem[13][1] = w;
    w = pos_mem[13][2];  w[31:0] = 32'h1000_0000; pos_mem[13][2]  = w;
    w = disp_mem[13][2]; w[31:0] = 32'hF000_0000; disp_mem[13][2] = w;
    run_pass();
    chk("n_out_c", cap_out.size(), 2);
    if (cap_out.size() == 2) begin
      w = cap_out[0][95:0];
      chk("x_wrap_up", w[31:0], 32'h1000_0000);
      chk("dst_x_wrap_up", cap_out[0][107:104], 4'd1);
      w = cap_out[1][95:0];
      chk("x_wrap_down", w[31:0], 32'h3000_0000);
      chk("dst_x_wrap_down", cap_out[1][107:104], 4'd3);
    end

    // clamped count plus random small cells
    clear_cells();
    for (int c = 0; c < 27; c++) set_cell(c, $urandom_range(0, 3));
    set_cell(5, 250);
    run_pass();
    chk("n_out_clamp_min", cap_out.size() >= 219, 1);

    // random passes
    for (int p = 0; p < 3; p++) begin
      clear_cells();
      for (int c = 0; c < 27; c++) set_cell(c, ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 6));
      run_pass();
    end

    // reset while streaming cell (2,1,1), then a clean full pass
    clear_cells();
    set_cell(0, 3);
    set_cell(9, 5);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    hit = 0;
    for (int k = 0; k < 200 && hit == 0; k++) begin
      if (out_rden && out_read_cell == 12'h211 && out_read_address == 8'd2) hit = 1;
      else @(negedge clk);
    end
    chk("reach_stream_211", hit, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("abort_outputs");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_all_zero("abort_held");
    end
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("abort_released");
    for (int c = 0; c < 27; c++) set_cell(c, $urandom_range(0, 4));
    run_pass();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
